// File: rtl/port_arbiter.sv
// Round-robin arbiter that multiplexes REQ_COUNT device word-pair sources onto one
// CPU input port pair, and routes CPU output-port writes back to the granted device.
module port_arbiter #(
  parameter int REQ_COUNT = 4,
  parameter int WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                halt,
  input  logic [REQ_COUNT-1:0]                req_valid,
  input  logic [REQ_COUNT-1:0][WIDTH-1:0]     req_data0,
  input  logic [REQ_COUNT-1:0][WIDTH-1:0]     req_data1,
  output logic [REQ_COUNT-1:0]                req_ready,
  output logic [WIDTH-1:0]                    cpu_d_in0,
  output logic [WIDTH-1:0]                    cpu_d_in1,
  output logic                                cpu_data_valid,
  output logic [$clog2(REQ_COUNT)-1:0]        cpu_src,
  input  logic                                cpu_inform_read,
  input  logic                                cpu_inform_write,
  input  logic [WIDTH-1:0]                    cpu_d_out0,
  input  logic [WIDTH-1:0]                    cpu_d_out1,
  output logic [REQ_COUNT-1:0]                dev_wr_valid,
  output logic [WIDTH-1:0]                    dev_wr_data0,
  output logic [WIDTH-1:0]                    dev_wr_data1
);

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic [WIDTH-1:0]     din0_q, din0_d;
  logic [WIDTH-1:0]     din1_q, din1_d;
  logic [REQ_COUNT-1:0] wr_vld_q;
  logic [WIDTH-1:0]     wr0_q, wr1_q;

  logic [IDX_W-1:0]     winner;
  logic                 found;
  logic [SUM_W-1:0]     scan;

  function automatic logic [REQ_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(REQ_COUNT - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Scan requesters starting at rr_ptr, wrapping modulo REQ_COUNT (need not be a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      scan = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (scan >= SUM_W'(REQ_COUNT)) scan = scan - SUM_W'(REQ_COUNT);
      if (!found && req_valid[scan[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    src_d          = src_q;
    din0_d         = din0_q;
    din1_d         = din1_q;
    cpu_data_valid = 1'b0;
    req_ready      = '0;
    case (state_q)
      IDLE: begin
        if (!halt && found) begin
          state_d  = HOLD;
          src_d    = winner;
          din0_d   = req_data0[winner];
          din1_d   = req_data1[winner];
          rr_ptr_d = next_idx(winner);
        end
      end
      HOLD: begin
        cpu_data_valid = 1'b1;
        if (cpu_inform_read) state_d = ACK;
      end
      ACK: begin
        req_ready = onehot(src_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are independent of the grant FSM and always target the current/last grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      din0_q   <= '0;
      din1_q   <= '0;
      wr_vld_q <= '0;
      wr0_q    <= '0;
      wr1_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      wr_vld_q <= cpu_inform_write ? onehot(src_q) : '0;
      if (cpu_inform_write) begin
        wr0_q <= cpu_d_out0;
        wr1_q <= cpu_d_out1;
      end
    end
  end

  assign cpu_d_in0    = din0_q;
  assign cpu_d_in1    = din1_q;
  assign cpu_src      = src_q;
  assign dev_wr_valid = wr_vld_q;
  assign dev_wr_data0 = wr0_q;
  assign dev_wr_data1 = wr1_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: stimulus pushes expected grant/ack/write events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_port_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             halt;
  logic [3:0]       req_valid;
  logic [3:0][15:0] req_data0;
  logic [3:0][15:0] req_data1;
  logic [3:0]       req_ready;
  logic [15:0]      cpu_d_in0;
  logic [15:0]      cpu_d_in1;
  logic             cpu_data_valid;
  logic [1:0]       cpu_src;
  logic             cpu_inform_read;
  logic             cpu_inform_write;
  logic [15:0]      cpu_d_out0;
  logic [15:0]      cpu_d_out1;
  logic [3:0]       dev_wr_valid;
  logic [15:0]      dev_wr_data0;
  logic [15:0]      dev_wr_data1;

  port_arbiter #(.REQ_COUNT(4), .WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt             (halt),
    .req_valid        (req_valid),
    .req_data0        (req_data0),
    .req_data1        (req_data1),
    .req_ready        (req_ready),
    .cpu_d_in0        (cpu_d_in0),
    .cpu_d_in1        (cpu_d_in1),
    .cpu_data_valid   (cpu_data_valid),
    .cpu_src          (cpu_src),
    .cpu_inform_read  (cpu_inform_read),
    .cpu_inform_write (cpu_inform_write),
    .cpu_d_out0       (cpu_d_out0),
    .cpu_d_out1       (cpu_d_out1),
    .dev_wr_valid     (dev_wr_valid),
    .dev_wr_data0     (dev_wr_data0),
    .dev_wr_data1     (dev_wr_data1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;

  ev_t gq[$];
  ev_t aq[$];
  ev_t wq[$];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] d0_tab [4] = '{16'h0055, 16'h1155, 16'h2255, 16'h3355};
  logic [15:0] d1_tab [4] = '{16'h0066, 16'h1166, 16'h2266, 16'h3366};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every DUT-presented event against the head of its queue.
  logic prev_v = 1'b0;
  ev_t  hs;
  always @(negedge clk) begin
    ev_t e;
    if (cpu_data_valid === 1'b1 && !prev_v) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", 32'(cpu_src), 32'hFFFF_FFFF);
      end else begin
        e = gq.pop_front();
        chk("grant_cycle", 32'(cyc), 32'(e.cyc));
        chk("grant_src", 32'(cpu_src), e.a);
        chk("grant_d0", 32'(cpu_d_in0), e.b);
        chk("grant_d1", 32'(cpu_d_in1), e.c);
        hs <= e;
      end
    end else if (cpu_data_valid === 1'b1) begin
      chk("hold_src", 32'(cpu_src), hs.a);
      chk("hold_d0", 32'(cpu_d_in0), hs.b);
    end
    if (req_ready !== 4'b0 && req_ready !== 4'bx) begin
      if (aq.size() == 0) begin
        chk("unexpected_ready", 32'(req_ready), 32'h0);
      end else begin
        e = aq.pop_front();
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("ready_mask", 32'(req_ready), e.a);
      end
    end
    if (dev_wr_valid !== 4'b0 && dev_wr_valid !== 4'bx) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(dev_wr_valid), 32'h0);
      end else begin
        e = wq.pop_front();
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
        chk("write_mask", 32'(dev_wr_valid), e.a);
        chk("write_d0", 32'(dev_wr_data0), e.b);
        chk("write_d1", 32'(dev_wr_data1), e.c);
      end
    end
    prev_v <= (cpu_data_valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int idx);
    ev_t e;
    e.cyc = cyc + 1; e.a = 32'(idx); e.b = 32'(d0_tab[idx]); e.c = 32'(d1_tab[idx]);
    gq.push_back(e);
  endtask

  task automatic push_ack(input int idx);
    ev_t e;
    e.cyc = cyc + 1; e.a = 32'(1) << idx; e.b = '0; e.c = '0;
    aq.push_back(e);
  endtask

  task automatic push_wr(input int idx, input logic [15:0] w0, input logic [15:0] w1);
    ev_t e;
    e.cyc = cyc + 1; e.a = 32'(1) << idx; e.b = 32'(w0); e.c = 32'(w1);
    wq.push_back(e);
  endtask

  // Grant on the next edge, read in HOLD, pass through ACK, end back in IDLE.
  task automatic grant_read(input int idx);
    push_grant(idx);
    tick();
    cpu_inform_read = 1'b1;
    push_ack(idx);
    tick();
    cpu_inform_read = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(cpu_data_valid), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_wr_valid"}, 32'(dev_wr_valid), 32'h0);
    chk({tag, "_src"}, 32'(cpu_src), 32'h0);
    chk({tag, "_d_in0"}, 32'(cpu_d_in0), 32'h0);
    chk({tag, "_d_in1"}, 32'(cpu_d_in1), 32'h0);
    chk({tag, "_wr_d0"}, 32'(dev_wr_data0), 32'h0);
    chk({tag, "_wr_d1"}, 32'(dev_wr_data1), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; req_valid = '0;
    cpu_inform_read = 1'b0; cpu_inform_write = 1'b0;
    cpu_d_out0 = '0; cpu_d_out1 = '0;
    for (int i = 0; i < 4; i++) begin
      req_data0[i] = d0_tab[i];
      req_data1[i] = d1_tab[i];
    end
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single requester, basic handshake
    req_valid = 4'b0001;
    grant_read(0);
    req_valid = 4'b0000;
    tick();

    // Fresh reset, then round-robin across four held requests
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 4'b1111;
    grant_read(0);
    grant_read(1);
    grant_read(2);
    grant_read(3);
    grant_read(0);
    req_valid = 4'b0000;
    tick();

    // Device 2 grant with same-cycle read and write, then back-to-back writes
    req_valid = 4'b0100;
    push_grant(2);
    tick();
    cpu_inform_read = 1'b1; cpu_inform_write = 1'b1;
    cpu_d_out0 = 16'h1234; cpu_d_out1 = 16'hABCD;
    push_ack(2);
    push_wr(2, 16'h1234, 16'hABCD);
    tick();
    cpu_inform_read = 1'b0; req_valid = 4'b0000;
    cpu_d_out0 = 16'h1111; cpu_d_out1 = 16'h2222;
    push_wr(2, 16'h1111, 16'h2222);
    tick();
    cpu_d_out0 = 16'h3333; cpu_d_out1 = 16'h4444;
    push_wr(2, 16'h3333, 16'h4444);
    tick();
    cpu_inform_write = 1'b0;
    tick();

    // Halt blocks the grant but not a write; halt in HOLD is ignored
    halt = 1'b1; req_valid = 4'b0010;
    cpu_inform_write = 1'b1; cpu_d_out0 = 16'h5555; cpu_d_out1 = 16'h6666;
    push_wr(2, 16'h5555, 16'h6666);
    tick();
    cpu_inform_write = 1'b0;
    tick();
    tick();
    tick();
    halt = 1'b0;
    push_grant(1);
    tick();
    halt = 1'b1; cpu_inform_read = 1'b1;
    push_ack(1);
    tick();
    cpu_inform_read = 1'b0; halt = 1'b0; req_valid = 4'b0000;
    tick();
    tick();

    // Reset while in HOLD: no ack, no write, pointer back to 0
    req_valid = 4'b0010;
    push_grant(1);
    tick();
    rst_n = 1'b0; cpu_inform_read = 1'b1; cpu_inform_write = 1'b1;
    cpu_d_out0 = 16'hDEAD; cpu_d_out1 = 16'hBEEF;
    tick();
    cpu_inform_read = 1'b0; cpu_inform_write = 1'b0;
    tick();
    check_zero("hold_reset");
    rst_n = 1'b1; req_valid = 4'b0110;
    grant_read(1);
    req_valid = 4'b0000;
    tick();
    tick();
    tick();

    chk("grant_queue_drained", 32'(gq.size()), 32'h0);
    chk("ready_queue_drained", 32'(aq.size()), 32'h0);
    chk("write_queue_drained", 32'(wq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter REQ_COUNT, default 4: number of device requesters sharing one CPU port pair (2..8).
REQ-002 SHALL have parameter WIDTH, default 16: port word width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port halt, input, 1: CPU halted; blocks new grants.
REQ-006 SHALL have port req_valid, input, REQ_COUNT: per-device "word pair available".
REQ-007 SHALL have port req_data0, input, REQ_COUNT x WIDTH: first word of each device.
REQ-008 SHALL have port req_data1, input, REQ_COUNT x WIDTH: second word of each device.
REQ-009 SHALL have port req_ready, output, REQ_COUNT: one-hot, one-cycle pair-consumed acknowledge.
REQ-010 SHALL have port cpu_d_in0, output, WIDTH: word driven onto the CPU port input, even index.
REQ-011 SHALL have port cpu_d_in1, output, WIDTH: word driven onto the CPU port input, odd index.
REQ-012 SHALL have port cpu_data_valid, output, 1: cpu_d_in0/1 hold a granted pair.
REQ-013 SHALL have port cpu_src, output, $clog2(REQ_COUNT): index of the current or last granted device.
REQ-014 SHALL have port cpu_inform_read, input, 1: CPU read the port pair this cycle.
REQ-015 SHALL have port cpu_inform_write, input, 1: CPU wrote the port pair this cycle.
REQ-016 SHALL have port cpu_d_out0, input, WIDTH: CPU output word, even index.
REQ-017 SHALL have port cpu_d_out1, input, WIDTH: CPU output word, odd index.
REQ-018 SHALL have port dev_wr_valid, output, REQ_COUNT: one-hot, one-cycle write strobe to a device.
REQ-019 SHALL have port dev_wr_data0, output, WIDTH: registered copy of cpu_d_out0.
REQ-020 SHALL have port dev_wr_data1, output, WIDTH: registered copy of cpu_d_out1.

Function
REQ-021 SHALL implement FSM states IDLE, HOLD and ACK.
REQ-022 SHALL, in IDLE with halt=0 and any req_valid set, select a winner round-robin starting at index rr_ptr, latch its req_data0/1 into cpu_d_in0/1, set cpu_src, and enter HOLD on the next edge.
REQ-023 SHALL assert cpu_data_valid exactly while in HOLD, i.e. one cycle after the winning req_valid is sampled.
REQ-024 SHALL update rr_ptr to (winner+1) mod REQ_COUNT on each grant.
REQ-025 SHALL, in HOLD, keep cpu_d_in0/1 and cpu_src stable until cpu_inform_read=1, ignoring req_valid changes (no retraction) and halt.
REQ-026 SHALL, on cpu_inform_read in HOLD, enter ACK, driving req_ready[cpu_src]=1 and cpu_data_valid=0 for exactly one cycle.
REQ-027 SHALL go from ACK to IDLE unconditionally, making the earliest next grant two cycles after the read.
REQ-028 SHALL ignore cpu_inform_read in IDLE and ACK.
REQ-029 SHALL keep cpu_d_in0/1 at their last latched value outside HOLD.
REQ-030 SHALL, on cpu_inform_write in any state, register cpu_d_out0/1 into dev_wr_data0/1 and pulse dev_wr_valid[cpu_src] for one cycle on the next edge.
REQ-031 SHALL, on back-to-back writes, produce one strobe per write with no loss.
REQ-032 SHALL service cpu_inform_read and cpu_inform_write in the same HOLD cycle independently; the write targets the current grant.
REQ-033 SHALL, with halt=1 in IDLE, stay in IDLE with rr_ptr unchanged; writes are still forwarded.

Reset
REQ-034 SHALL, when rst_n=0 at a clock edge, force state IDLE, rr_ptr=0, cpu_src=0, cpu_d_in0/1=0, dev_wr_data0/1=0, and cpu_data_valid, req_ready and dev_wr_valid all zero.
REQ-035 SHALL, on reset during HOLD or ACK, abandon the grant without issuing req_ready, and SHALL not forward a write sampled during reset.

Verification
REQ-036 SHALL cover: after reset, req_valid=4'b0001, req_data0=0x0055, req_data1=0x0066 -> next cycle cpu_data_valid=1, cpu_d_in0=0x0055, cpu_d_in1=0x0066, cpu_src=0; cpu_inform_read -> req_ready=4'b0001 for one cycle, then IDLE.
REQ-037 SHALL cover: req_valid=4'b1111 held, four read cycles -> grants in order 0,1,2,3, then 0 again.
REQ-038 SHALL cover: grant device 2, then cpu_inform_write with cpu_d_out0=0x1234 -> dev_wr_valid=4'b0100 and dev_wr_data0=0x1234 one cycle later; a same-cycle read acknowledges device 2.
REQ-039 SHALL cover: halt=1 with req_valid=4'b0010 -> cpu_data_valid stays 0; deassert halt -> grant to device 1 one cycle later.
REQ-040 SHALL cover: rst_n=0 while in HOLD -> all outputs zero, no req_ready pulse; after release, a pending request is granted from index 0.
